drp_rmw_master: RTL and testbench
=================================

# drp_rmw_master

DRP initiator driving the DRP port of transceiver primitives (GT common/channel, QPLL registers). It accepts single-register read, write and masked-write requests from the PHY control logic. It serialises them onto the DRP handshake, performing read-modify-write in hardware for partial masks. Each request returns one response carrying read data or a timeout error.

## Interface
- `ADDR_W`, default 9: DRP address width; `drp_addr` is zero-extended by the wrapper as needed.
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles to wait for `drp_rdy` after each `drp_en` pulse. Legal range 1..65535.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  DRP clock; all logic sits on this edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  register address.
- `req_wdata`  in  16  write data.
- `req_wmask`  in  16  bit-enable for the write; 1 = take bit from `req_wdata`.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_rdata`  out  16  read data. For RMW this is the pre-modify value. For a full write it is 0.
- `rsp_err`  out  1  DRP timeout occurred.
- `drp_en`  out  1  DRP strobe, exactly one cycle per access.
- `drp_we`  out  1  DRP write enable, qualified by `drp_en`.
- `drp_addr`  out  ADDR_W  DRP address.
- `drp_di`  out  16  DRP write data.
- `drp_do`  in  16  DRP read data, valid with `drp_rdy`.
- `drp_rdy`  in  1  DRP access complete.

## Operation
- FSM states: IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RESP.
- IDLE: `req_ready`=1. Acceptance latches addr, wdata and mask, then selects the first state:
  - read → RD_EN.
  - write with mask 16'hFFFF → WR_EN.
  - write with any other mask → RD_EN, with the RMW flag set.
- RD_EN / WR_EN:
  - Last one cycle.
  - `drp_en`=1 in both.
  - `drp_we`=1 in WR_EN only.
  - Address and data are stable during the strobe.
  - Next state is the matching WAIT state. The timeout counter clears.
- RD_WAIT, when `drp_rdy` arrives:
  - Capture `drp_do`.
  - If RMW is set and mask != 0: compute `drp_di` = (rd & ~mask) | (wdata & mask), then go to WR_EN.
  - Otherwise go to RESP. A write with mask 0 is read-only and no DRP write is issued.
- WR_WAIT: `drp_rdy` → RESP.
- Timeout:
  - In either WAIT state, the counter increments each cycle without `drp_rdy`.
  - When the counter reaches TIMEOUT_CYCLES, set `rsp_err`=1 and go to RESP.
  - A read timeout in RMW aborts the sequence; no write is issued.
- RESP: `rsp_valid`=1. `rsp_valid && rsp_ready` → IDLE.
- `drp_rdy` outside the WAIT states is ignored. This includes a late `drp_rdy` after a timeout.
- Reset values:
  - `req_ready`=0 while `rst` is asserted; 1 in the first cycle after release (IDLE).
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `drp_en`=0, `drp_we`=0, `drp_addr`=0, `drp_di`=0.
- Reset mid-access: the FSM returns to IDLE immediately. `drp_en` drops asynchronously and no response is produced.

## Timing
- Accept at cycle N → `drp_en` at N+1.
- Read: `drp_rdy` at cycle M (M ≥ N+2) → `rsp_valid` at M+1.
- RMW: read `drp_rdy` at cycle M → write `drp_en` at M+1, with `drp_di` registered and valid in that cycle.
- Timeout: no `drp_rdy` in cycles E+1..E+TIMEOUT_CYCLES, where E is the `drp_en` cycle → `rsp_valid` with `rsp_err` at E+TIMEOUT_CYCLES+1.
- Throughput: one outstanding request. `req_ready` is 0 from acceptance until the cycle after the response handshake.
- All outputs are registered.

## Configuration
- `DRP_RMW_EN`, defined:
  - Partial-mask writes perform read-modify-write as described above.
  - Mask 0 performs a read only.
- `DRP_RMW_EN`, undefined:
  - `req_wmask` is ignored and every write is a single full write of `req_wdata`.
  - The RMW path, the mask register and the merge logic are removed.

## Structure
- `drp_pkg` contains:
  - the `drp_state_e` enum;
  - `DRP_DATA_W`=16;
  - `DRP_FULL_MASK`=16'hFFFF.
- One sub-module, `drp_timeout_timer`: loadable counter with clear, enable and `expired` outputs, parameterised by TIMEOUT_CYCLES.

## Test plan
- Read addr 0x05: responder returns 0xBEEF with `drp_rdy` 3 cycles after `drp_en` → one `drp_en` pulse with `drp_we`=0, then `rsp_rdata`=0xBEEF, `rsp_err`=0.
- Write 0x1234 to 0x10 with mask 0xFFFF → one `drp_en` with `drp_we`=1 and `drp_di`=0x1234. No read is issued and `rsp_rdata`=0.
- RMW: register holds 0xAAAA; write 0x00FF with mask 0x0F0F → read, then write `drp_di`=0xA0AF; `rsp_rdata`=0xAAAA. Without `DRP_RMW_EN`: a single write of 0x00FF.
- No `drp_rdy` with TIMEOUT_CYCLES=8 → `rsp_err`=1 exactly 9 cycles after `drp_en`. In the RMW case, no write strobe follows.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0. A stray `drp_rdy` during this time has no effect.
- Assert `rst` during RD_WAIT → `drp_en`=0 and `rsp_valid`=0 immediately. After release, a fresh read completes normally.

Source files
------------

// File: rtl/drp_pkg.sv
// Shared types and constants for the DRP read-modify-write master.
package drp_pkg;

   localparam int unsigned DRP_DATA_W = 16;
   localparam logic [DRP_DATA_W-1:0] DRP_FULL_MASK = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_EN   = 3'd1,
      RD_WAIT = 3'd2,
      WR_EN   = 3'd3,
      WR_WAIT = 3'd4,
      RESP    = 3'd5
   } drp_state_e;

   // Bits set in mask come from new data, the rest keep the register's value.
   function automatic logic [DRP_DATA_W-1:0] drp_merge(input logic [DRP_DATA_W-1:0] rd,
                                                       input logic [DRP_DATA_W-1:0] wd,
                                                       input logic [DRP_DATA_W-1:0] mask);
      return (rd & ~mask) | (wd & mask);
   endfunction

endpackage

// File: rtl/drp_rmw_master_if.sv
// Request/response and DRP port bundle; master is the initiator, slave its environment.
interface drp_rmw_master_if
   import drp_pkg::*;
#(
   parameter int unsigned ADDR_W = 9
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [DRP_DATA_W-1:0] req_wdata;
   logic [DRP_DATA_W-1:0] req_wmask;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DRP_DATA_W-1:0] rsp_rdata;
   logic                  rsp_err;

   logic                  drp_en;
   logic                  drp_we;
   logic [ADDR_W-1:0]     drp_addr;
   logic [DRP_DATA_W-1:0] drp_di;
   logic [DRP_DATA_W-1:0] drp_do;
   logic                  drp_rdy;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output drp_en, drp_we, drp_addr, drp_di,
      input  drp_do, drp_rdy
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wmask,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  drp_en, drp_we, drp_addr, drp_di,
      output drp_do, drp_rdy
   );

endinterface

// File: rtl/drp_timeout_timer.sv
// Wait-state timeout counter: cleared on each strobe, counts cycles without drp_rdy,
// and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module drp_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_c_o
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_c_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/drp_rmw_master.sv
// DRP initiator serialising read / write / masked-write requests onto the DRP handshake.
// Define DRP_RMW_EN to perform hardware read-modify-write for partial write masks.
module drp_rmw_master
   import drp_pkg::*;
#(
   parameter int unsigned ADDR_W         = 9,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   drp_rmw_master_if.master  bus
);

   drp_state_e            state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DRP_DATA_W-1:0] di_q, di_d;
   logic [DRP_DATA_W-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  drp_en_q, drp_en_d;
   logic                  drp_we_q, drp_we_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  tmr_clr_c;
   logic                  tmr_en_c;
   logic                  tmr_exp_c;

`ifdef DRP_RMW_EN
   logic [DRP_DATA_W-1:0] wdata_q, wdata_d;
   logic [DRP_DATA_W-1:0] mask_q, mask_d;
   logic                  rmw_q, rmw_d;
`else
   logic                  unused_wmask;
   assign unused_wmask = ^bus.req_wmask;
`endif

   drp_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (tmr_clr_c),
      .en_i        (tmr_en_c),
      .expired_c_o (tmr_exp_c)
   );

   // Next state, datapath updates and registered output values.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      di_d      = di_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      tmr_clr_c = 1'b0;
      tmr_en_c  = 1'b0;
`ifdef DRP_RMW_EN
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      rmw_d     = rmw_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               addr_d  = bus.req_addr;
               di_d    = bus.req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
`ifdef DRP_RMW_EN
               wdata_d = bus.req_wdata;
               mask_d  = bus.req_wmask;
               rmw_d   = bus.req_write && (bus.req_wmask != DRP_FULL_MASK);
               state_d = (bus.req_write && !rmw_d) ? WR_EN : RD_EN;
`else
               state_d = bus.req_write ? WR_EN : RD_EN;
`endif
            end
         end
         RD_EN: begin
            tmr_clr_c = 1'b1;
            state_d   = RD_WAIT;
         end
         RD_WAIT: begin
            tmr_en_c = !bus.drp_rdy;
            if (bus.drp_rdy) begin
               rdata_d = bus.drp_do;
               state_d = RESP;
`ifdef DRP_RMW_EN
               // Mask 0 degenerates to a plain read: nothing to write back.
               if (rmw_q && (mask_q != '0)) begin
                  di_d    = drp_merge(bus.drp_do, wdata_q, mask_q);
                  state_d = WR_EN;
               end
`endif
            end else if (tmr_exp_c) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         WR_EN: begin
            tmr_clr_c = 1'b1;
            state_d   = WR_WAIT;
         end
         WR_WAIT: begin
            tmr_en_c = !bus.drp_rdy;
            if (bus.drp_rdy) begin
               state_d = RESP;
            end else if (tmr_exp_c) begin
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      drp_en_d    = (state_d == RD_EN) || (state_d == WR_EN);
      drp_we_d    = (state_d == WR_EN);
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         di_q        <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         drp_en_q    <= 1'b0;
         drp_we_q    <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         di_q        <= di_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         drp_en_q    <= drp_en_d;
         drp_we_q    <= drp_we_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

`ifdef DRP_RMW_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdata_q <= '0;
         mask_q  <= '0;
         rmw_q   <= 1'b0;
      end else begin
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         rmw_q   <= rmw_d;
      end
   end
`endif

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.drp_en    = drp_en_q;
   assign bus.drp_we    = drp_we_q;
   assign bus.drp_addr  = addr_q;
   assign bus.drp_di    = di_q;

endmodule

// File: tb/tb_drp_rmw_master.sv
// Self-checking bench for drp_rmw_master: directed vector table, reset sequences,
// then randomized requests against a register-level reference model.
`timescale 1ns/1ps
module tb_drp_rmw_master;

   localparam int unsigned AW = 9;
   localparam int unsigned TO = 8;
`ifdef DRP_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   drp_rmw_master_if #(.ADDR_W(AW)) bus ();

   drp_rmw_master #(
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // DRP register device
   logic [15:0]   dev_mem [512];
   logic [15:0]   ref_mem [512];
   bit            resp_off  = 1'b0;
   int            rdy_dly   = 1;
   bit            stray_req = 1'b0;
   int            n_rd      = 0;
   int            n_wr      = 0;
   logic [AW-1:0] last_addr = '0;

   initial begin
      int          pend;
      logic [15:0] pdata;
      pend  = 0;
      pdata = '0;
      bus.drp_rdy = 1'b0;
      bus.drp_do  = '0;
      forever begin
         @(posedge clk); #1;
         bus.drp_rdy = 1'b0;
         if (rst) pend = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.drp_rdy = 1'b1;
               bus.drp_do  = pdata;
            end
         end else if (stray_req) begin
            bus.drp_rdy = 1'b1;
            bus.drp_do  = 16'hDEAD;
            stray_req   = 1'b0;
         end
         if (bus.drp_en) begin
            last_addr = bus.drp_addr;
            if (bus.drp_we) n_wr++;
            else            n_rd++;
            if (!resp_off) begin
               pend = rdy_dly;
               if (bus.drp_we) begin
                  dev_mem[bus.drp_addr] = bus.drp_di;
                  pdata = 16'h0000;
               end else begin
                  pdata = dev_mem[bus.drp_addr];
               end
            end
         end
      end
   end

   task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [15:0] wd,
                          input logic [15:0] m, input int dly, input bit noresp, input int hold,
                          output logic [15:0] rd, output logic er, output int lat,
                          output int nrd, output int nwr);
      int t;
      int n0;
      int rd0;
      int wr0;
      bit stable;
      rdy_dly  = dly;
      resp_off = noresp;
      t = 0;
      while (!bus.req_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      rd0 = n_rd;
      wr0 = n_wr;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      bus.req_wmask = m;
      n0 = cyc;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      t = 0;
      while (!bus.rsp_valid && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
      lat = cyc - n0;
      rd  = bus.rsp_rdata;
      er  = bus.rsp_err;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (i == 0 && hold >= 2) stray_req = 1'b1;
         @(posedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd || bus.rsp_err !== er ||
             bus.req_ready !== 1'b0) stable = 1'b0;
      end
      if (hold > 0) chk("rsp_hold_stable", 32'(stable), 32'd1);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
      chk("req_ready_back", 32'(bus.req_ready), 32'd1);
      if (noresp) stray_req = 1'b1;
      nrd = n_rd - rd0;
      nwr = n_wr - wr0;
   endtask

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [15:0]   wd;
      logic [15:0]   m;
      int            dly;
      bit            noresp;
      int            hold;
      logic [15:0]   e_rd;
      logic          e_err;
      int            e_lat;
      int            e_nrd;
      int            e_nwr;
      logic [15:0]   e_mem;
   } vec_t;

   vec_t vt [9];

   initial begin
      logic [15:0] rd;
      logic        er;
      int          lat;
      int          nrd;
      int          nwr;
      bit          seen;

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wmask = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 512; i++) begin
         dev_mem[i] = '0;
         ref_mem[i] = '0;
      end
      dev_mem[9'h005] = 16'hBEEF;
      dev_mem[9'h020] = 16'hAAAA;
      dev_mem[9'h030] = 16'h5A5A;

      //          w     a       wd        m         dly nr    hold e_rd                        err   lat          nrd          nwr  e_mem
      vt[0] = '{1'b0, 9'h005, 16'h0000, 16'h0000, 3, 1'b0, 0, 16'hBEEF,                   1'b0, 5,           1,           0, 16'hBEEF};
      vt[1] = '{1'b1, 9'h010, 16'h1234, 16'hFFFF, 2, 1'b0, 0, 16'h0000,                   1'b0, 4,           0,           1, 16'h1234};
      vt[2] = '{1'b1, 9'h020, 16'h00FF, 16'h0F0F, 1, 1'b0, 0, RMW ? 16'hAAAA : 16'h0000,  1'b0, RMW ? 5 : 3, RMW ? 1 : 0, 1, RMW ? 16'hA0AF : 16'h00FF};
      vt[3] = '{1'b0, 9'h030, 16'h0000, 16'h0000, 1, 1'b1, 0, 16'h0000,                   1'b1, TO + 2,      1,           0, 16'h5A5A};
      vt[4] = '{1'b1, 9'h020, 16'h1234, 16'h00F0, 1, 1'b1, 0, 16'h0000,                   1'b1, TO + 2,      RMW ? 1 : 0, RMW ? 0 : 1, RMW ? 16'hA0AF : 16'h00FF};
      vt[5] = '{1'b0, 9'h005, 16'h0000, 16'h0000, 1, 1'b0, 5, 16'hBEEF,                   1'b0, 3,           1,           0, 16'hBEEF};
      vt[6] = '{1'b1, 9'h005, 16'hFFFF, 16'h0000, 2, 1'b0, 0, RMW ? 16'hBEEF : 16'h0000,  1'b0, 4,           RMW ? 1 : 0, RMW ? 0 : 1, RMW ? 16'hBEEF : 16'hFFFF};
      vt[7] = '{1'b0, 9'h010, 16'h0000, 16'h0000, TO, 1'b0, 0, 16'h1234,                  1'b0, TO + 2,      1,           0, 16'h1234};
      vt[8] = '{1'b0, 9'h010, 16'h0000, 16'h0000, TO + 1, 1'b0, 0, 16'h0000,              1'b1, TO + 2,      1,           0, 16'h1234};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata",  32'(bus.rsp_rdata), 32'd0);
      chk("rst_rsp_err",    32'(bus.rsp_err),   32'd0);
      chk("rst_drp_en",     32'(bus.drp_en),    32'd0);
      chk("rst_drp_we",     32'(bus.drp_we),    32'd0);
      chk("rst_drp_addr",   32'(bus.drp_addr),  32'd0);
      chk("rst_drp_di",     32'(bus.drp_di),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         run_req(vt[i].w, vt[i].a, vt[i].wd, vt[i].m, vt[i].dly, vt[i].noresp, vt[i].hold,
                 rd, er, lat, nrd, nwr);
         chk($sformatf("v%0d_rdata", i), 32'(rd),  32'(vt[i].e_rd));
         chk($sformatf("v%0d_err", i),   32'(er),  32'(vt[i].e_err));
         chk($sformatf("v%0d_lat", i),   32'(lat), 32'(vt[i].e_lat));
         chk($sformatf("v%0d_nrd", i),   32'(nrd), 32'(vt[i].e_nrd));
         chk($sformatf("v%0d_nwr", i),   32'(nwr), 32'(vt[i].e_nwr));
         chk($sformatf("v%0d_addr", i),  32'(last_addr), 32'(vt[i].a));
         chk($sformatf("v%0d_mem", i),   32'(dev_mem[vt[i].a]), 32'(vt[i].e_mem));
      end

      // Reset while waiting for the read to complete
      resp_off = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 9'h007;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("rstw_strobe", 32'(bus.drp_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstw_drp_en",    32'(bus.drp_en),    32'd0);
      chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rstw_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rstw_ready_after", 32'(bus.req_ready), 32'd1);

      // Reset in the middle of a write strobe drops it without waiting for a clock
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 9'h040;
      bus.req_wdata = 16'h5555;
      bus.req_wmask = 16'hFFFF;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("rsts_pre_en", 32'(bus.drp_en), 32'd1);
      chk("rsts_pre_we", 32'(bus.drp_we), 32'd1);
      chk("rsts_pre_di", 32'(bus.drp_di), 32'h5555);
      rst = 1'b1;
      #1;
      chk("rsts_drp_en",   32'(bus.drp_en),   32'd0);
      chk("rsts_drp_we",   32'(bus.drp_we),   32'd0);
      chk("rsts_drp_addr", 32'(bus.drp_addr), 32'd0);
      chk("rsts_drp_di",   32'(bus.drp_di),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < TO + 4; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid || bus.drp_en) seen = 1'b1;
      end
      chk("rsts_no_rsp", 32'(seen), 32'd0);
      run_req(1'b0, 9'h010, 16'h0, 16'h0, 2, 1'b0, 0, rd, er, lat, nrd, nwr);
      chk("rsts_fresh_rdata", 32'(rd),  32'h1234);
      chk("rsts_fresh_err",   32'(er),  32'd0);
      chk("rsts_fresh_lat",   32'(lat), 32'd4);

      // Randomized requests against the register model
      for (int i = 0; i < 16; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         dev_mem[i] = v;
         ref_mem[i] = v;
      end
      for (int k = 0; k < 40; k++) begin
         logic          w;
         logic [AW-1:0] a;
         logic [15:0]   wd;
         logic [15:0]   m;
         int            dly;
         bit            nr;
         int            hold;
         logic [15:0]   old;
         logic [15:0]   nxt;
         logic [15:0]   e_rd;
         int            e_nrd;
         int            e_nwr;
         int            e_lat;
         w    = 1'($urandom_range(0, 1));
         a    = AW'($urandom_range(0, 15));
         wd   = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       m = 16'hFFFF;
            1:       m = 16'h0000;
            default: m = 16'($urandom);
         endcase
         dly  = int'($urandom_range(1, 4));
         nr   = ($urandom_range(0, 7) == 0);
         hold = int'($urandom_range(0, 2));

         old = ref_mem[a];
         nxt = old;
         if (!w) begin
            e_nrd = 1; e_nwr = 0; e_rd = old;
         end else if (RMW && m != 16'hFFFF) begin
            e_nrd = 1; e_nwr = (m != 16'h0000) ? 1 : 0; e_rd = old;
            nxt = (old & ~m) | (wd & m);
         end else begin
            e_nrd = 0; e_nwr = 1; e_rd = 16'h0000;
            nxt = wd;
         end
         if (nr) begin
            e_rd  = 16'h0000;
            e_lat = TO + 2;
            if (e_nrd == 1) e_nwr = 0;
         end else begin
            e_lat = 1 + (e_nrd + e_nwr) * (dly + 1);
            ref_mem[a] = nxt;
         end

         run_req(w, a, wd, m, dly, nr, hold, rd, er, lat, nrd, nwr);
         chk($sformatf("r%0d_rdata", k), 32'(rd),  32'(e_rd));
         chk($sformatf("r%0d_err", k),   32'(er),  32'(nr));
         chk($sformatf("r%0d_lat", k),   32'(lat), 32'(e_lat));
         chk($sformatf("r%0d_nrd", k),   32'(nrd), 32'(e_nrd));
         chk($sformatf("r%0d_nwr", k),   32'(nwr), 32'(e_nwr));
         chk($sformatf("r%0d_mem", k),   32'(dev_mem[a]), 32'(ref_mem[a]));
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
